mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the top-level controller FSM and the image BRAM. In mode 1 it streams the whole image out of BRAM. In mode 2 it fetches a three-row window (edge-clamped) around the current image row into the line buffer that feeds the core. It owns the image-row counter that the controller and the 7-segment display read.

## Interface
- MAX_ROW, 360, image rows
- MAX_COL, 540, image columns
- BRAM_AW, 18, BRAM address width (covers MAX_ROW*MAX_COL)
- BUF_AW, 11, line-buffer address width (covers 3*MAX_COL)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- is_mode1_i  in  1  controller in mode 1 (select or run)
- mode1_run_i  in  1  level; full-image stream requested
- is_mode2_i  in  1  controller in mode 2 (select, fetch or core)
- fetch_run_i  in  1  level; window fetch requested
- core_run_i  in  1  core stage active
- core_done_i  in  1  core finished current row
- cnt_len_i  in  20  words to transfer; sampled at start
- bram_en_o  out  1  BRAM read enable
- bram_addr_o  out  BRAM_AW  BRAM read address
- bram_rdata_i  in  8  BRAM data; valid one cycle after bram_en_o
- buf_wr_en_o  out  1  line-buffer write strobe (mode 2)
- buf_wr_addr_o  out  BUF_AW  line-buffer address, 0..3*MAX_COL-1
- buf_wr_data_o  out  8  line-buffer write data
- out_valid_o  out  1  mode-1 stream valid; sink always accepts
- out_data_o  out  8  mode-1 stream data
- mode1_done_o  out  1  one-cycle pulse, mode-1 stream complete
- fetch_done_o  out  1  one-cycle pulse, window fetch complete
- cnt_img_row_o  out  10  current image row

## Operation
- FSM states: M_IDLE, M_READ, M_DRAIN, M_DONE.
- Start: in M_IDLE, mode1_run_i or fetch_run_i high. Mode 1 has priority if both are high.
  - Latch the operation kind and cnt_len_i, clear the word counter w.
  - If cnt_len_i==0, go to M_DONE; otherwise go to M_READ.
- M_READ: bram_en_o=1 each cycle and w increments.
  - After issuing word len-1, go to M_DRAIN.
- M_DRAIN: one cycle while the last read returns, then go to M_DONE.
- M_DONE: assert the matching done pulse for one cycle, then go to M_IDLE.
- Mode 1 address: bram_addr_o=w.
- Mode 2 address:
  - Segment s=w/MAX_COL (0..2), column c=w%MAX_COL.
  - Source row = clamp(cnt_img_row+s-1, 0, MAX_ROW-1).
  - bram_addr_o = srcrow*MAX_COL + c.
  - buf_wr_addr_o = w, delayed one cycle.
  - Track s and c as counters; do not divide.
- Data path: a read issued in cycle k returns in cycle k+1.
  - Mode 2: buf_wr_en_o=1 and buf_wr_data_o=bram_rdata_i in cycle k+1.
  - Mode 1: out_valid_o=1 and out_data_o=bram_rdata_i in cycle k+1.
- Abort: if the run input for the active operation drops in M_READ or M_DRAIN, go to M_IDLE next cycle.
  - No done pulse; the in-flight read is discarded (no write or valid).
- Row counter:
  - Clears to 0 when is_mode1_i is high, or when is_mode2_i & !fetch_run_i & !core_run_i (mode-2 select).
  - Increments on core_run_i & core_done_i while below MAX_ROW-1.
  - Saturates at MAX_ROW-1.
  - Otherwise holds, so the display keeps showing 359 after completion.
- Reset values: all outputs and counters are 0; FSM is in M_IDLE.

## Timing
- Cycle 0 is the first cycle run is high in M_IDLE.
- Addresses 0..N-1 are issued in cycles 1..N.
- Writes or valids occur in cycles 2..N+1.
- Done pulse is in cycle N+2. For N=0 the done pulse is in cycle 1.
- Throughput: one word per cycle with no bubbles.
- Done pulse is exactly one cycle wide. The controller drops run in the following cycle, and M_IDLE samples run again only from cycle N+3.
- Row counter update is registered: it changes the cycle after core_done_i and is stable before the next fetch_run_i.

## Structure
- Package mem_ctrl_pkg holds:
  - the FSM state enum;
  - MAX_ROW/MAX_COL defaults;
  - BRAM_AW and BUF_AW;
  - the MODE1_LEN (194400) and FETCH_LEN (1620) constants shared with the controller.
- Sub-module mem_addr_gen holds:
  - the w, s and c counters;
  - clamped source-row selection;
  - BRAM and buffer address generation.
- The top level holds the FSM, the row counter and the data pipeline.

## Test plan
- Mode 1, cnt_len=194400 → 194400 consecutive out_valid beats with addresses 0..194399. mode1_done_o pulses in cycle 194402. No buf_wr_en_o.
- Mode 2, row 0, len 1620 → buffer words 0..539 and 540..1079 both come from BRAM 0..539 (clamped row). Words 1080..1619 come from 540..1079. fetch_done_o pulses in cycle 1622.
- Mode 2, row 359 → segment 2 reads BRAM 193860..194399 (clamped row 359). Segment 0 reads BRAM 193320..193859 (row 358).
- 360 fetch/core_done cycles → cnt_img_row_o steps 0..359 and saturates. An extra core_done_i leaves it at 359.
- Abort and reset:
  - fetch_run_i dropped at w=100 → M_IDLE next cycle, no fetch_done_o, no write after that cycle.
  - rst_n low mid-mode-1 → all outputs 0 asynchronously.
- cnt_len_i=0 with fetch_run_i → fetch_done_o in cycle 1, no bram_en_o.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state type and image/BRAM geometry constants.
//   Used by mem_ctrl, mem_addr_gen and the top-level controller.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {M_IDLE, M_READ, M_DRAIN, M_DONE} state_t;
  localparam int MAX_ROW   = 360;
  localparam int MAX_COL   = 540;
  localparam int BRAM_AW   = 18;
  localparam int BUF_AW    = 11;
  localparam int MODE1_LEN = MAX_ROW * MAX_COL;
  localparam int FETCH_LEN = 3 * MAX_COL;
endpackage

// File: rtl/mem_addr_gen.sv
// mem_addr_gen: word/segment/column counters and BRAM + line-buffer address generation.
//   clk, rst_n       clock, async active-low reset
//   clr, inc         clear counters at start / advance one word per issued read
//   mode2            1: clamped three-row window addressing, 0: linear stream
//   row              current image row
//   w                word counter
//   bram_addr        BRAM read address for the current word
//   buf_addr         line-buffer address, w delayed to line up with returning data
module mem_addr_gen
  import mem_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               mode2,
  input  logic [9:0]         row,
  output logic [19:0]        w,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [BUF_AW-1:0]  buf_addr
);
  localparam logic [9:0]  COL_LAST = 10'(MAX_COL - 1);
  localparam logic [10:0] ROW_LAST = 11'(MAX_ROW - 1);
  logic [1:0]  s;
  logic [9:0]  c;
  logic [10:0] sum, up, src;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w        <= '0;
      s        <= '0;
      c        <= '0;
      buf_addr <= '0;
    end else begin
      if (clr) begin
        w <= '0;
        s <= '0;
        c <= '0;
      end else if (inc) begin
        w <= w + 20'd1;
        s <= (c == COL_LAST) ? s + 2'd1 : s;
        c <= (c == COL_LAST) ? 10'd0 : c + 10'd1;
      end
      buf_addr <= w[BUF_AW-1:0];
    end
  end
  // source row = clamp(row + s - 1, 0, MAX_ROW-1); sum==0 is the row -1 case
  always_comb begin
    sum       = {1'b0, row} + {9'b0, s};
    up        = sum - 11'd1;
    src       = (sum == 11'd0) ? 11'd0 : (up > ROW_LAST ? ROW_LAST : up);
    bram_addr = mode2 ? BRAM_AW'(src) * BRAM_AW'(MAX_COL) + BRAM_AW'(c) : w[BRAM_AW-1:0];
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: BRAM read controller for the mode-1 image stream and mode-2 three-row window fetch.
//   clk, rst_n                        clock, async active-low reset
//   is_mode1_i, is_mode2_i            controller mode flags (row counter clearing)
//   mode1_run_i, fetch_run_i          level run requests; dropping one aborts its operation
//   core_run_i, core_done_i           core stage handshake advancing the image row
//   cnt_len_i                         words to transfer, sampled at start
//   bram_en_o, bram_addr_o, bram_rdata_i   BRAM read port, one-cycle latency
//   buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o  line-buffer write port (mode 2)
//   out_valid_o, out_data_o           mode-1 stream
//   mode1_done_o, fetch_done_o        one-cycle completion pulses
//   cnt_img_row_o                     current image row
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               is_mode1_i,
  input  logic               mode1_run_i,
  input  logic               is_mode2_i,
  input  logic               fetch_run_i,
  input  logic               core_run_i,
  input  logic               core_done_i,
  input  logic [19:0]        cnt_len_i,
  output logic               bram_en_o,
  output logic [BRAM_AW-1:0] bram_addr_o,
  input  logic [7:0]         bram_rdata_i,
  output logic               buf_wr_en_o,
  output logic [BUF_AW-1:0]  buf_wr_addr_o,
  output logic [7:0]         buf_wr_data_o,
  output logic               out_valid_o,
  output logic [7:0]         out_data_o,
  output logic               mode1_done_o,
  output logic               fetch_done_o,
  output logic [9:0]         cnt_img_row_o
);
  localparam logic [9:0] ROW_LAST = 10'(MAX_ROW - 1);
  state_t      state, nxt;
  logic        kind;
  logic [19:0] len, w;
  logic        run, start, last, inc, rd_v, rd_w;
  mem_addr_gen u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .inc       (inc),
    .mode2     (kind),
    .row       (cnt_img_row_o),
    .w         (w),
    .bram_addr (bram_addr_o),
    .buf_addr  (buf_wr_addr_o)
  );
  assign run   = kind ? fetch_run_i : mode1_run_i;
  assign start = (state == M_IDLE) && (mode1_run_i || fetch_run_i);
  assign last  = (w == len - 20'd1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= M_IDLE;
    else        state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      M_IDLE:  nxt = !start ? M_IDLE : (cnt_len_i == 20'd0 ? M_DONE : M_READ);
      M_READ:  nxt = !run ? M_IDLE : (last ? M_DRAIN : M_READ);
      M_DRAIN: nxt = !run ? M_IDLE : M_DONE;
      M_DONE:  nxt = M_IDLE;
      default: nxt = M_IDLE;
    endcase
  end
  always_comb begin
    bram_en_o    = (state == M_READ);
    inc          = (state == M_READ);
    mode1_done_o = (state == M_DONE) && !kind;
    fetch_done_o = (state == M_DONE) && kind;
  end
  // a read issued in the abort cycle is never marked valid, so it is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind          <= 1'b0;
      len           <= '0;
      rd_v          <= 1'b0;
      rd_w          <= 1'b0;
      cnt_img_row_o <= '0;
    end else begin
      if (start) begin
        kind <= !mode1_run_i;
        len  <= cnt_len_i;
      end
      rd_v <= (state == M_READ) && run && !kind;
      rd_w <= (state == M_READ) && run && kind;
      if (is_mode1_i || (is_mode2_i && !fetch_run_i && !core_run_i))
        cnt_img_row_o <= '0;
      else if (core_run_i && core_done_i && cnt_img_row_o < ROW_LAST)
        cnt_img_row_o <= cnt_img_row_o + 10'd1;
    end
  end
  assign out_valid_o   = rd_v;
  assign out_data_o    = rd_v ? bram_rdata_i : 8'd0;
  assign buf_wr_en_o   = rd_w;
  assign buf_wr_data_o = rd_w ? bram_rdata_i : 8'd0;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a behavioural BRAM and window model.
module tb_mem_ctrl;
  localparam int MAX_ROW = 360;
  localparam int MAX_COL = 540;
  logic        clk = 0, rst_n = 0;
  logic        is_mode1_i = 0, mode1_run_i = 0, is_mode2_i = 0, fetch_run_i = 0;
  logic        core_run_i = 0, core_done_i = 0;
  logic [19:0] cnt_len_i = 0;
  logic        bram_en_o;
  logic [17:0] bram_addr_o;
  logic [7:0]  bram_rdata_i = 0;
  logic        buf_wr_en_o;
  logic [10:0] buf_wr_addr_o;
  logic [7:0]  buf_wr_data_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        mode1_done_o, fetch_done_o;
  logic [9:0]  cnt_img_row_o;
  int n_chk = 0, n_fail = 0;

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .is_mode1_i(is_mode1_i), .mode1_run_i(mode1_run_i),
    .is_mode2_i(is_mode2_i), .fetch_run_i(fetch_run_i), .core_run_i(core_run_i),
    .core_done_i(core_done_i), .cnt_len_i(cnt_len_i), .bram_en_o(bram_en_o),
    .bram_addr_o(bram_addr_o), .bram_rdata_i(bram_rdata_i), .buf_wr_en_o(buf_wr_en_o),
    .buf_wr_addr_o(buf_wr_addr_o), .buf_wr_data_o(buf_wr_data_o), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .mode1_done_o(mode1_done_o), .fetch_done_o(fetch_done_o),
    .cnt_img_row_o(cnt_img_row_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] img(int a);
    return 8'((a * 37) ^ (a >> 9));
  endfunction

  always @(posedge clk) bram_rdata_i <= bram_en_o ? img(int'(bram_addr_o)) : 8'($urandom);

  function automatic int win_addr(int row, int j);
    int r;
    r = row + j / MAX_COL - 1;
    r = r < 0 ? 0 : (r > MAX_ROW - 1 ? MAX_ROW - 1 : r);
    return r * MAX_COL + j % MAX_COL;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, " bram_en"}, bram_en_o, 0);
    chk({tag, " bram_addr"}, bram_addr_o, 0);
    chk({tag, " buf_wr_en"}, buf_wr_en_o, 0);
    chk({tag, " buf_wr_addr"}, buf_wr_addr_o, 0);
    chk({tag, " buf_wr_data"}, buf_wr_data_o, 0);
    chk({tag, " out_valid"}, out_valid_o, 0);
    chk({tag, " out_data"}, out_data_o, 0);
    chk({tag, " mode1_done"}, mode1_done_o, 0);
    chk({tag, " fetch_done"}, fetch_done_o, 0);
    chk({tag, " row"}, cnt_img_row_o, 0);
  endtask

  task automatic set_row(int r);
    @(negedge clk);
    is_mode1_i = 0; is_mode2_i = 1; fetch_run_i = 0; core_run_i = 0; core_done_i = 0;
    @(negedge clk);
    core_run_i = 1; core_done_i = (r > 0);
    repeat (r) @(negedge clk);
    core_done_i = 0;
    chk("set_row", cnt_img_row_o, r);
  endtask

  // abort_at: cycle in which the run input is dropped (0 = never); exp_done: done cycle (0 = none)
  task automatic run_op(bit m2, int len, int row, int abort_at, int exp_done);
    int last;
    bit en_e, dat_e;
    string t;
    if (m2) set_row(row);
    @(negedge clk);
    cnt_len_i = 20'(len);
    if (m2) begin
      is_mode1_i = 0; is_mode2_i = 1; core_run_i = 0; fetch_run_i = 1;
    end else begin
      is_mode2_i = 0; is_mode1_i = 1; mode1_run_i = 1;
    end
    last = exp_done != 0 ? exp_done + 1 : abort_at + 3;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      t = $sformatf("%s len=%0d row=%0d cyc=%0d", m2 ? "m2" : "m1", len, row, cyc);
      en_e  = cyc >= 1 && cyc <= len && (abort_at == 0 || cyc <= abort_at);
      dat_e = cyc >= 2 && cyc <= len + 1 && (abort_at == 0 || cyc <= abort_at);
      chk({t, " bram_en"}, bram_en_o, en_e);
      if (en_e) chk({t, " bram_addr"}, bram_addr_o, m2 ? win_addr(row, cyc - 1) : cyc - 1);
      chk({t, " buf_wr_en"}, buf_wr_en_o, m2 && dat_e);
      chk({t, " out_valid"}, out_valid_o, !m2 && dat_e);
      if (dat_e && m2) begin
        chk({t, " buf_wr_addr"}, buf_wr_addr_o, cyc - 2);
        chk({t, " buf_wr_data"}, buf_wr_data_o, img(win_addr(row, cyc - 2)));
      end
      if (dat_e && !m2) chk({t, " out_data"}, out_data_o, img(cyc - 2));
      chk({t, " fetch_done"}, fetch_done_o, m2 && cyc == exp_done);
      chk({t, " mode1_done"}, mode1_done_o, !m2 && cyc == exp_done);
      if (cyc == exp_done || cyc == abort_at) begin
        mode1_run_i = 0; fetch_run_i = 0;
        if (m2) core_run_i = 1;
      end
    end
    if (m2) chk({t, " row held"}, cnt_img_row_o, row);
  endtask

  typedef struct {
    bit m2;
    int len;
    int row;
    int abort_at;
    int exp_done;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 0, 0, 0, 1};
    vecs[1] = '{1, 0, 7, 0, 1};
    vecs[2] = '{0, 1, 0, 0, 3};
    vecs[3] = '{0, 50, 0, 0, 52};
    vecs[4] = '{1, 1620, 0, 0, 1622};
    vecs[5] = '{1, 1620, 359, 0, 1622};
    vecs[6] = '{1, 1620, 5, 0, 1622};
    vecs[7] = '{1, 1620, 10, 101, 0};
    vecs[8] = '{0, 300, 0, 50, 0};
    vecs[9] = '{1, 600, 200, 0, 602};

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1;
    @(negedge clk);
    chk_idle_outputs("after reset");

    foreach (vecs[i]) run_op(vecs[i].m2, vecs[i].len, vecs[i].row, vecs[i].abort_at, vecs[i].exp_done);

    for (int k = 0; k < 6; k++) begin
      bit m2;
      int len, row;
      m2  = 1'($urandom);
      len = m2 ? int'($urandom_range(0, 1620)) : int'($urandom_range(0, 2000));
      row = int'($urandom_range(0, MAX_ROW - 1));
      run_op(m2, len, row, 0, len == 0 ? 1 : len + 2);
    end

    // row counter sweep: steps one per core_done and saturates at MAX_ROW-1
    set_row(0);
    @(negedge clk);
    core_done_i = 1;
    for (int k = 1; k <= MAX_ROW + 1; k++) begin
      @(negedge clk);
      chk($sformatf("row sweep k=%0d", k), cnt_img_row_o, k < MAX_ROW ? k : MAX_ROW - 1);
    end
    core_done_i = 0; core_run_i = 0; fetch_run_i = 1;
    @(negedge clk);
    chk("row hold in fetch", cnt_img_row_o, MAX_ROW - 1);
    fetch_run_i = 0; core_run_i = 1;
    @(negedge clk);
    chk("row hold in core", cnt_img_row_o, MAX_ROW - 1);
    core_run_i = 0;
    @(negedge clk);
    chk("row clear in select", cnt_img_row_o, 0);

    // asynchronous reset mid-stream
    is_mode2_i = 0; is_mode1_i = 1; mode1_run_i = 1; cnt_len_i = 20'd300;
    repeat (20) @(negedge clk);
    chk("pre-reset bram_en", bram_en_o, 1);
    chk("pre-reset out_valid", out_valid_o, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk_idle_outputs("async reset");
    @(negedge clk);
    mode1_run_i = 0;
    rst_n = 1;
    @(negedge clk);
    chk_idle_outputs("post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
